// File: rtl/mdunit.sv
// mdunit: iterative 32-bit multiply/divide unit for the EX stage.
// MULT/MULTU use LSB-first shift-add; DIV/DIVU use MSB-first restoring
// division. Both take 32 RUN cycles plus one FIX cycle that applies sign
// correction and writes HI/LO. MTHI/MTLO write HI/LO directly from IDLE.
module mdunit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  mdop,
    input  logic [31:0] rsdata,
    input  logic [31:0] rtdata,
    input  logic        flush,
    output logic        busy,
    output logic        stall,
    output logic        done,
    output logic [31:0] hiout,
    output logic [31:0] loout
);

    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    // a_q: |multiplicand|, or |dividend| shifting out while quotient shifts in
    logic [31:0] a_q, a_d;
    // b_q: |multiplier| (shifted right each step) or |divisor| (held)
    logic [31:0] b_q, b_d;
    // acc_q: partial product for multiply; low 33 bits are the remainder for divide
    logic [63:0] acc_q, acc_d;
    logic        div_q, div_d;
    logic        nega_q, nega_d;
    logic        negb_q, negb_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic [32:0] shifted;
    logic [32:0] sum;
    logic [63:0] prod;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;
    logic        signed_op;

    function automatic logic [31:0] neg32(input logic [31:0] x);
        return ~x + 32'd1;
    endfunction

    function automatic logic [63:0] neg64(input logic [63:0] x);
        return ~x + 64'd1;
    endfunction

    // Next-state, datapath step and HI/LO write selection
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        a_d       = a_q;
        b_d       = b_q;
        acc_d     = acc_q;
        div_d     = div_q;
        nega_d    = nega_q;
        negb_d    = negb_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        shifted   = 33'd0;
        sum       = 33'd0;
        prod      = 64'd0;
        quo_fix   = 32'd0;
        rem_fix   = 32'd0;
        signed_op = (mdop == OP_MULT) || (mdop == OP_DIV);

        case (state_q)
            S_IDLE: begin
                if (start && !flush) begin
                    case (mdop)
                        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                            nega_d  = signed_op && rsdata[31];
                            negb_d  = signed_op && rtdata[31];
                            a_d     = (signed_op && rsdata[31]) ? neg32(rsdata) : rsdata;
                            b_d     = (signed_op && rtdata[31]) ? neg32(rtdata) : rtdata;
                            acc_d   = 64'd0;
                            cnt_d   = 5'd0;
                            div_d   = (mdop == OP_DIV) || (mdop == OP_DIVU);
                            state_d = S_RUN;
                        end
                        OP_MTHI: hi_d = rsdata;
                        OP_MTLO: lo_d = rsdata;
                        default: ;
                    endcase
                end
            end
            S_RUN: begin
                if (div_q) begin
                    // Bring in the next dividend bit and try to subtract the divisor
                    shifted = {acc_q[31:0], a_q[31]};
                    if (shifted >= {1'b0, b_q}) begin
                        acc_d = {31'd0, shifted - {1'b0, b_q}};
                        a_d   = {a_q[30:0], 1'b1};
                    end else begin
                        acc_d = {31'd0, shifted};
                        a_d   = {a_q[30:0], 1'b0};
                    end
                end else begin
                    // Add multiplicand into the high half when the current multiplier bit is set
                    sum   = {1'b0, acc_q[63:32]} + {1'b0, (b_q[0] ? a_q : 32'd0)};
                    acc_d = {sum, acc_q[31:1]};
                    b_d   = {1'b0, b_q[31:1]};
                end
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                if (div_q) begin
                    quo_fix = (nega_q ^ negb_q) ? neg32(a_q) : a_q;
                    rem_fix = nega_q ? neg32(acc_q[31:0]) : acc_q[31:0];
                    // With a zero divisor the remainder equals |dividend|, so
                    // undoing |.| restores the dividend exactly as latched.
                    if (b_q == 32'd0) begin
                        lo_d = 32'hFFFF_FFFF;
                        hi_d = rem_fix;
                    end else begin
                        lo_d = quo_fix;
                        hi_d = rem_fix;
                    end
                end else begin
                    prod = (nega_q ^ negb_q) ? neg64(acc_q) : acc_q;
                    hi_d = prod[63:32];
                    lo_d = prod[31:0];
                end
                done_d  = 1'b1;
                cnt_d   = 5'd0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // A squash abandons everything: no HI/LO write and no done pulse
        if (flush) begin
            state_d = S_IDLE;
            cnt_d   = 5'd0;
            hi_d    = hi_q;
            lo_d    = lo_q;
            done_d  = 1'b0;
        end

        busy_d = (state_d != S_IDLE);
    end

    // State, datapath and architectural HI/LO registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 5'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            acc_q   <= 64'd0;
            div_q   <= 1'b0;
            nega_q  <= 1'b0;
            negb_q  <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            div_q   <= div_d;
            nega_q  <= nega_d;
            negb_q  <= negb_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy  = busy_q;
    assign stall = busy_q;
    assign done  = done_q;
    assign hiout = hi_q;
    assign loout = lo_q;

endmodule

// File: tb/tb_mdunit.sv
// Testbench for mdunit: scoreboard of expected {HI,LO} per mult/div issue,
// consumed by a monitor on every done pulse; directed cases plus random ops.
module tb_mdunit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [2:0]  mdop;
    logic [31:0] rsdata;
    logic [31:0] rtdata;
    logic        flush;
    logic        busy;
    logic        stall;
    logic        done;
    logic [31:0] hiout;
    logic [31:0] loout;

    int n_checks = 0;
    int n_pass   = 0;
    logic [63:0] exp_q[$];
    logic [31:0] model_hi;
    logic [31:0] model_lo;

    mdunit dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .mdop   (mdop),
        .rsdata (rsdata),
        .rtdata (rtdata),
        .flush  (flush),
        .busy   (busy),
        .stall  (stall),
        .done   (done),
        .hiout  (hiout),
        .loout  (loout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, expv);
    endtask

    // Reference: plain 64-bit arithmetic on the architectural definitions
    function automatic logic [63:0] ref_model(input logic [2:0] op, input logic [31:0] rs,
                                              input logic [31:0] rt);
        longint          p;
        longint unsigned pu;
        int              q;
        int              r;
        case (op)
            3'd1: begin
                p = longint'($signed(rs)) * longint'($signed(rt));
                return p;
            end
            3'd2: begin
                pu = 64'(rs) * 64'(rt);
                return pu;
            end
            3'd3: begin
                if (rt == 32'd0) return {rs, 32'hFFFF_FFFF};
                if (rs == 32'h8000_0000 && rt == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                q = $signed(rs) / $signed(rt);
                r = $signed(rs) % $signed(rt);
                return {r, q};
            end
            3'd4: begin
                if (rt == 32'd0) return {rs, 32'hFFFF_FFFF};
                return {rs % rt, rs / rt};
            end
            default: return {model_hi, model_lo};
        endcase
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (rst_n === 1'b1 && done === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_done: done=1 with hi=%h lo=%h, expected no result", hiout, loout);
            end else begin
                chk("result_hilo", {hiout, loout}, exp_q.pop_front());
            end
        end
    end

    task automatic issue(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt);
        logic [63:0] e;
        @(negedge clk);
        start  = 1'b1;
        mdop   = op;
        rsdata = rs;
        rtdata = rt;
        e = ref_model(op, rs, rt);
        exp_q.push_back(e);
        model_hi = e[63:32];
        model_lo = e[31:0];
        @(posedge clk);
        #1;
        start = 1'b0;
        mdop  = 3'd0;
    endtask

    task automatic wait_done(output int busy_cycles);
        bit seen = 0;
        busy_cycles = 0;
        @(negedge clk);
        for (int i = 0; i < 100; i++) begin
            if (done === 1'b1) begin
                seen = 1;
                break;
            end
            if (busy === 1'b1) busy_cycles++;
            @(negedge clk);
        end
        if (!seen) begin
            n_checks++;
            $display("FAIL done_timeout: no done within 100 cycles, expected done");
        end else begin
            @(negedge clk);
            chk("done_one_cycle", {63'd0, done}, 64'd0);
        end
    endtask

    task automatic do_op(input string name, input logic [2:0] op, input logic [31:0] rs,
                         input logic [31:0] rt);
        int bc;
        issue(op, rs, rt);
        wait_done(bc);
        chk({name, "_busy_cycles"}, 64'(bc), 64'd33);
    endtask

    initial begin
        int bc;
        logic [2:0]  rop;
        logic [31:0] rrs;
        logic [31:0] rrt;

        rst_n = 1'b0; start = 1'b0; mdop = 3'd0; rsdata = 32'd0; rtdata = 32'd0; flush = 1'b0;
        model_hi = 32'd0; model_lo = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_hilo", {hiout, loout}, 64'd0);
        chk("reset_ctrl", {61'd0, busy, stall, done}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        do_op("multu_max", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        do_op("mult_neg", 3'd1, 32'hFFFF_FFFD, 32'd7);
        do_op("div_neg", 3'd3, 32'hFFFF_FFF9, 32'd2);
        do_op("divu_zero", 3'd4, 32'd100, 32'd0);
        do_op("div_ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        do_op("div_zero_neg", 3'd3, 32'hFFFF_FF00, 32'd0);

        // MTHI then MTLO back-to-back: one edge each, never busy
        @(negedge clk);
        start = 1'b1; mdop = 3'b101; rsdata = 32'h1234_5678;
        @(posedge clk); #1;
        chk("mthi_hi", 64'(hiout), 64'h1234_5678);
        chk("mthi_busy", {62'd0, busy, stall}, 64'd0);
        mdop = 3'b110; rsdata = 32'hCAFE_BABE;
        @(posedge clk); #1;
        chk("mtlo_lo", 64'(loout), 64'hCAFE_BABE);
        chk("mtlo_busy", {62'd0, busy, stall}, 64'd0);
        start = 1'b0; mdop = 3'd0;
        model_hi = 32'h1234_5678; model_lo = 32'hCAFE_BABE;

        // Flush in RUN cycle 10: no write, no done
        @(negedge clk);
        start = 1'b1; mdop = 3'd1; rsdata = 32'd1234; rtdata = 32'd5678;
        @(posedge clk); #1;
        start = 1'b0; mdop = 3'd0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("pre_flush_busy", {63'd0, busy}, 64'd1);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_busy", {63'd0, busy}, 64'd0);
        repeat (40) @(posedge clk);
        #1;
        chk("flush_hilo", {hiout, loout}, {model_hi, model_lo});

        // Flush together with mthi: nothing accepted
        @(negedge clk);
        start = 1'b1; mdop = 3'b101; rsdata = 32'hDEAD_BEEF; flush = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; mdop = 3'd0; flush = 1'b0;
        chk("flush_mthi", 64'(hiout), 64'(model_hi));

        // Starts while busy are ignored
        issue(3'd2, 32'd1000, 32'd3000);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            start = 1'b1; mdop = (i % 2 == 0) ? 3'b101 : 3'd4;
            rsdata = $urandom; rtdata = $urandom;
        end
        @(negedge clk);
        start = 1'b0; mdop = 3'd0;
        wait_done(bc);
        chk("busy_ignore_hi", 64'(hiout), 64'(model_hi));

        // Asynchronous reset mid-RUN
        issue(3'd1, 32'hFFFF_0000, 32'h0001_2345);
        repeat (15) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midreset_hilo", {hiout, loout}, 64'd0);
        chk("midreset_ctrl", {62'd0, busy, done}, 64'd0);
        void'(exp_q.pop_back());
        model_hi = 32'd0; model_lo = 32'd0;
        @(negedge clk);
        rst_n = 1'b1;
        do_op("multu_6x7", 3'd2, 32'd6, 32'd7);

        // Randomized mult/div with edge-biased operands
        for (int i = 0; i < 24; i++) begin
            rop = 3'($urandom_range(1, 4));
            rrs = $urandom;
            if ($urandom_range(0, 7) == 0) rrs = 32'h8000_0000;
            case ($urandom_range(0, 7))
                0: rrt = 32'd0;
                1: rrt = 32'hFFFF_FFFF;
                2: rrt = 32'($urandom_range(1, 9));
                default: rrt = $urandom;
            endcase
            do_op("random", rop, rrs, rrt);
        end

        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
